// File: rtl/enet_tx_sched.sv
// Two-source Ethernet TX nibble scheduler: round-robin grant, start timeout, max-length
// truncation, abort handling and a fixed inter-packet gap, all paced by the nibble strobe.
module enet_tx_sched #(
  parameter logic [11:0] MAXLEN  = 12'd3036,
  parameter logic [4:0]  IPG     = 5'd24,
  parameter logic [4:0]  STARTTO = 5'd16
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ce,
  input  logic [1:0] i_req,
  input  logic       i_a_v,
  input  logic [3:0] i_a_nibble,
  input  logic       i_b_v,
  input  logic [3:0] i_b_nibble,
  input  logic [1:0] i_macen,
  input  logic       i_abort,
  output logic [1:0] o_gnt,
  output logic       o_v,
  output logic [3:0] o_nibble,
  output logic       o_en,
  output logic       o_cancel,
  output logic       o_busy
);

  typedef enum logic [1:0] {StIdle, StWait, StXmit, StGap} state_e;

  state_e      r_state;
  logic [1:0]  r_gnt;
  logic        r_last_b;  // 1 when source B was granted most recently
  logic        r_en;
  logic        r_v;
  logic [3:0]  r_nibble;
  logic        r_cancel;
  logic [11:0] r_cnt;
  logic [4:0]  r_tmr;     // shared by the start timeout (WAIT) and the gap (GAP)

  logic        w_sel_b;
  logic        w_src_v;
  logic        w_src_req;
  logic [3:0]  w_src_nibble;

  // On a tie, grant whichever source was not granted last.
  assign w_sel_b      = i_req[1] & (~i_req[0] | ~r_last_b);
  assign w_src_v      = (r_gnt[0] & i_a_v) | (r_gnt[1] & i_b_v);
  assign w_src_req    = |(r_gnt & i_req);
  assign w_src_nibble = r_gnt[1] ? i_b_nibble : i_a_nibble;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state  <= StIdle;
      r_gnt    <= 2'b00;
      r_last_b <= 1'b1;
      r_en     <= 1'b0;
      r_v      <= 1'b0;
      r_nibble <= 4'h0;
      r_cancel <= 1'b0;
      r_cnt    <= 12'd0;
      r_tmr    <= 5'd0;
    end else if (i_ce) begin
      r_cancel <= 1'b0;
      if (r_state != StIdle && i_abort) begin
        r_cancel <= 1'b1;
        r_v      <= 1'b0;
        r_gnt    <= 2'b00;
        r_tmr    <= 5'd0;
        r_state  <= StGap;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (|i_req) begin
              r_gnt    <= w_sel_b ? 2'b10 : 2'b01;
              r_last_b <= w_sel_b;
              r_en     <= w_sel_b ? i_macen[1] : i_macen[0];
              r_tmr    <= 5'd0;
              r_state  <= StWait;
            end
          end
          StWait: begin
            if (w_src_v) begin
              r_v      <= 1'b1;
              r_nibble <= w_src_nibble;
              r_cnt    <= 12'd1;
              r_state  <= StXmit;
            end else if (!w_src_req) begin
              r_gnt   <= 2'b00;
              r_state <= StIdle;
            end else if (r_tmr == STARTTO - 5'd1) begin
              r_gnt    <= 2'b00;
              r_cancel <= 1'b1;
              r_state  <= StIdle;
            end else begin
              r_tmr <= r_tmr + 5'd1;
            end
          end
          StXmit: begin
            if (!w_src_v || r_cnt == MAXLEN) begin
              // A still-valid source at MAXLEN is truncated and flagged downstream.
              r_cancel <= w_src_v;
              r_v      <= 1'b0;
              r_gnt    <= 2'b00;
              r_tmr    <= 5'd0;
              r_state  <= StGap;
            end else begin
              r_nibble <= w_src_nibble;
              r_cnt    <= r_cnt + 12'd1;
            end
          end
          StGap: begin
            if (r_tmr == IPG - 5'd1) begin
              r_state <= StIdle;
            end else begin
              r_tmr <= r_tmr + 5'd1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_gnt    = r_gnt;
  assign o_v      = r_v;
  assign o_nibble = r_nibble;
  assign o_en     = r_en;
  assign o_cancel = r_cancel;
  assign o_busy   = (r_state != StIdle);

endmodule

// File: tb/tb_enet_tx_sched.sv
// Scoreboard bench for enet_tx_sched: directed packets push expected nibbles and grants into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_enet_tx_sched;

  logic       i_clk = 1'b0;
  logic       i_reset_n, i_ce, i_a_v, i_b_v, i_abort;
  logic [1:0] i_req, i_macen;
  logic [3:0] i_a_nibble, i_b_nibble;
  logic [1:0] o_gnt;
  logic       o_v, o_en, o_cancel, o_busy;
  logic [3:0] o_nibble;

  enet_tx_sched dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_req(i_req),
    .i_a_v(i_a_v), .i_a_nibble(i_a_nibble), .i_b_v(i_b_v), .i_b_nibble(i_b_nibble),
    .i_macen(i_macen), .i_abort(i_abort), .o_gnt(o_gnt), .o_v(o_v), .o_nibble(o_nibble),
    .o_en(o_en), .o_cancel(o_cancel), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  int cancel_cnt = 0;
  int onehot_bad = 0;
  logic [3:0] exp_nib[$];
  logic [1:0] exp_gnt[$];
  logic       strobe_edge = 1'b0;
  logic [1:0] prev_gnt = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  always @(posedge i_clk) strobe_edge <= i_ce & i_reset_n;

  // Monitor: grants on any change to a non-zero value, data and cancels on strobe edges only.
  always @(negedge i_clk) begin
    if (o_gnt == 2'b11) onehot_bad++;
    if (o_gnt != 2'b00 && o_gnt != prev_gnt) begin
      if (exp_gnt.size() == 0) unexpected("gnt_unexpected", o_gnt);
      else chk("gnt_order", o_gnt, exp_gnt.pop_front());
    end
    prev_gnt <= o_gnt;
    if (strobe_edge) begin
      if (o_v === 1'b1) begin
        if (exp_nib.size() == 0) unexpected("nibble_unexpected", o_nibble);
        else chk("nibble_data", o_nibble, exp_nib.pop_front());
      end
      if (o_cancel === 1'b1) cancel_cnt++;
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic strobe();
    i_ce = 1'b1;
    step();
    i_ce = 1'b0;
    step();
  endtask

  int n, c0, cidx;
  logic busy_at_cancel, gnt_at_cancel_zero;

  initial begin
    i_reset_n = 1'b0; i_ce = 1'b0; i_req = 2'b00; i_macen = 2'b00; i_abort = 1'b0;
    i_a_v = 1'b0; i_b_v = 1'b0; i_a_nibble = 4'h0; i_b_nibble = 4'h0;
    repeat (3) step();
    chk("rst_gnt", o_gnt, 2'b00);
    chk("rst_v", o_v, 1'b0);
    chk("rst_nibble", o_nibble, 4'h0);
    chk("rst_en", o_en, 1'b0);
    chk("rst_cancel", o_cancel, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    i_reset_n = 1'b1; i_ce = 1'b1;

    // Tie from reset: A first; B noise must never leak; B queued through A's gap.
    i_req = 2'b11; i_macen = 2'b01; i_b_v = 1'b1; i_b_nibble = 4'hA;
    exp_gnt.push_back(2'b01);
    step();
    chk("tie_gnt_a", o_gnt, 2'b01);
    chk("tie_en_a", o_en, 1'b1);
    chk("tie_busy", o_busy, 1'b1);
    for (int i = 0; i < 128; i++) begin
      i_a_v = 1'b1; i_a_nibble = 4'((i * 7 + 3) & 15);
      exp_nib.push_back(i_a_nibble);
      step();
    end
    i_a_v = 1'b0; i_b_v = 1'b0; i_req = 2'b10;
    exp_gnt.push_back(2'b10);
    step();
    chk("end_v", o_v, 1'b0);
    chk("end_gnt", o_gnt, 2'b00);
    chk("end_cancel", o_cancel, 1'b0);
    n = 0;
    while (o_gnt != 2'b10 && n < 60) begin step(); n++; end
    // 24 gap strobes, then one arbitration strobe in IDLE.
    chk("ipg_to_gnt_b", n, 25);
    chk("en_b", o_en, 1'b0);

    // B withdraws its request before valid: silent return to IDLE.
    i_req = 2'b00;
    step();
    chk("drop_gnt", o_gnt, 2'b00);
    chk("drop_busy", o_busy, 1'b0);
    chk("drop_cancel", o_cancel, 1'b0);

    // A streams 0x1..0xF; o_en must ignore i_macen changes mid-packet.
    i_req = 2'b01; i_macen = 2'b00;
    exp_gnt.push_back(2'b01);
    step();
    chk("seq_gnt", o_gnt, 2'b01);
    i_macen = 2'b11;
    for (int i = 1; i < 16; i++) begin
      i_a_v = 1'b1; i_a_nibble = 4'(i);
      exp_nib.push_back(4'(i));
      step();
    end
    i_a_v = 1'b0; i_req = 2'b00;
    step();
    chk("seq_en_hold", o_en, 1'b0);
    n = 0;
    while (o_busy && n < 60) begin step(); n++; end
    chk("seq_gap_len", n, 24);

    // A granted but never valid: start timeout.
    i_req = 2'b01;
    exp_gnt.push_back(2'b01);
    step();
    c0 = cancel_cnt;
    n = 0;
    while (!o_cancel && n < 40) begin step(); n++; end
    chk("timeout_strobe", n, 16);
    chk("timeout_gnt", o_gnt, 2'b00);
    chk("timeout_busy", o_busy, 1'b0);
    chk("timeout_v", o_v, 1'b0);
    i_req = 2'b00;
    step();
    chk("timeout_pulse_len", o_cancel, 1'b0);
    chk("timeout_cancel_cnt", cancel_cnt - c0, 1);

    // B oversize packet: truncated after nibble MAXLEN.
    i_req = 2'b11;
    exp_gnt.push_back(2'b10);
    step();
    chk("long_gnt_b", o_gnt, 2'b10);
    i_req = 2'b10;
    c0 = cancel_cnt; cidx = -1; busy_at_cancel = 1'b0; gnt_at_cancel_zero = 1'b0;
    for (int i = 0; i < 3100; i++) begin
      i_b_v = 1'b1; i_b_nibble = 4'(i) ^ 4'h5;
      if (i < 3036) exp_nib.push_back(i_b_nibble);
      step();
      if (o_cancel && cidx < 0) begin
        cidx = i; i_req = 2'b00;
        busy_at_cancel = o_busy; gnt_at_cancel_zero = (o_gnt == 2'b00);
      end
    end
    i_b_v = 1'b0;
    chk("long_cancel_idx", cidx, 3036);
    chk("long_cancel_cnt", cancel_cnt - c0, 1);
    chk("long_gap_busy", busy_at_cancel, 1'b1);
    chk("long_gnt_clear", gnt_at_cancel_zero, 1'b1);
    chk("long_v_after", o_v, 1'b0);

    // Abort mid-packet with a 1-in-2 strobe.
    i_req = 2'b01;
    exp_gnt.push_back(2'b01);
    strobe();
    for (int i = 0; i < 5; i++) begin
      i_a_v = 1'b1; i_a_nibble = 4'(i + 8);
      exp_nib.push_back(i_a_nibble);
      strobe();
    end
    c0 = cancel_cnt;
    i_abort = 1'b1; i_a_nibble = 4'hF; i_req = 2'b00;
    strobe();
    i_abort = 1'b0; i_a_v = 1'b0;
    chk("abort_v", o_v, 1'b0);
    chk("abort_gnt", o_gnt, 2'b00);
    chk("abort_cancel_held", o_cancel, 1'b1);
    n = 0;
    while (o_busy && n < 60) begin strobe(); n++; end
    chk("abort_busy_strobes", n, 24);
    chk("abort_cancel_cnt", cancel_cnt - c0, 1);
    i_ce = 1'b1;

    // Reset during XMIT, asserted with i_ce low.
    i_req = 2'b10; i_macen = 2'b10;
    exp_gnt.push_back(2'b10);
    step();
    for (int i = 0; i < 3; i++) begin
      i_b_v = 1'b1; i_b_nibble = 4'(i + 1);
      exp_nib.push_back(i_b_nibble);
      step();
    end
    c0 = cancel_cnt;
    i_reset_n = 1'b0; i_ce = 1'b0;
    step();
    chk("mrst_gnt", o_gnt, 2'b00);
    chk("mrst_v", o_v, 1'b0);
    chk("mrst_nibble", o_nibble, 4'h0);
    chk("mrst_en", o_en, 1'b0);
    chk("mrst_cancel", o_cancel, 1'b0);
    chk("mrst_busy", o_busy, 1'b0);
    i_reset_n = 1'b1; i_ce = 1'b1; i_req = 2'b00; i_b_v = 1'b0;
    step();
    step();
    chk("mrst_no_cancel", cancel_cnt - c0, 0);

    chk("nib_queue_empty", exp_nib.size(), 0);
    chk("gnt_queue_empty", exp_gnt.size(), 0);
    chk("gnt_onehot", onehot_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
